// File: rtl/pcint_ctrl_pkg.sv
// Shared constants for the pin-change interrupt controller: register offsets,
// PCCTL bit positions and the I/O window address helpers.
package pcint_ctrl_pkg;

  typedef enum logic [2:0] {
    REG_PCMSK = 3'd0,
    REG_PCRIS = 3'd1,
    REG_PCFAL = 3'd2,
    REG_PCFLG = 3'd3,
    REG_PCCTL = 3'd4
  } pcint_reg_e;

  localparam int NUM_REGS = 5;
  localparam int PCCTL_IE = 0;
  localparam int PCCTL_FE = 1;
  localparam int CNT_W    = 4;

  // Addresses below the base wrap to large unsigned offsets and miss the window.
  function automatic logic adr_hit(input logic [5:0] adr, input logic [5:0] base);
    logic [6:0] diff;
    diff = {1'b0, adr} - {1'b0, base};
    return (diff < 7'(NUM_REGS));
  endfunction

  function automatic logic [2:0] adr_off(input logic [5:0] adr, input logic [5:0] base);
    logic [5:0] diff;
    diff = adr - base;
    return diff[2:0];
  endfunction

endpackage

// File: rtl/pcint_filter.sv
// One pin: two-flop synchronizer plus optional stability filter producing the
// accepted level f and single-edge rise/fall strobes aligned with the f update.
module pcint_filter
  import pcint_ctrl_pkg::*;
#(
  parameter int FILT_CYC = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  input  logic fe_i,
  output logic f_o,
  output logic rise_raw_o,
  output logic fall_raw_o
);

  logic             s1_q, s2_q, f_q, f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next accepted level and stability count
  always_comb begin
    f_d   = f_q;
    cnt_d = '0;
    if (!fe_i) begin
      f_d = s2_q;
    end else if (s2_q != f_q) begin
      if (cnt_q == CNT_W'(FILT_CYC - 1)) begin
        f_d = s2_q;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchronizer and filter state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      f_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= pin_i;
      s2_q  <= s1_q;
      f_q   <= f_d;
      cnt_q <= cnt_d;
    end
  end

  assign f_o        = f_q;
  assign rise_raw_o = f_d & ~f_q;
  assign fall_raw_o = ~f_d & f_q;

endmodule

// File: rtl/pcint_ctrl.sv
// Pin-change interrupt controller: I/O register window, per-pin edge
// qualification, write-1-to-clear pending flags and the interrupt request.
module pcint_ctrl
  import pcint_ctrl_pkg::*;
#(
  parameter int         BITS     = 8,
  parameter logic [5:0] ADR_BASE = 6'h0C,
  parameter int         FILT_CYC = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ena_i,
  input  logic [5:0]      adr_i,
  input  logic [7:0]      data_i,
  output logic [7:0]      data_o,
  input  logic            re_i,
  input  logic            we_i,
  output logic            selected_o,
  input  logic [BITS-1:0] port_i,
  output logic            irq_o,
  input  logic            irq_ack_i
);

  logic [BITS-1:0] msk_q, msk_d, ris_q, ris_d, fal_q, fal_d, flg_q, flg_d;
  logic [1:0]      ctl_q, ctl_d;
  logic [BITS-1:0] rise_raw, fall_raw, f_lvl_unused;
  logic [BITS-1:0] ev, wr_clr, ack_clr;
  logic [7:0]      rd_data;
  logic            hit, wr;
  pcint_reg_e      reg_off;

  assign hit     = adr_hit(adr_i, ADR_BASE);
  assign reg_off = pcint_reg_e'(adr_off(adr_i, ADR_BASE));
  assign wr      = we_i & ena_i & hit;

  for (genvar g = 0; g < BITS; g++) begin : g_pin
    pcint_filter #(.FILT_CYC(FILT_CYC)) u_filt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .pin_i      (port_i[g]),
      .fe_i       (ctl_q[PCCTL_FE]),
      .f_o        (f_lvl_unused[g]),
      .rise_raw_o (rise_raw[g]),
      .fall_raw_o (fall_raw[g])
    );
  end

  assign ev = (rise_raw & msk_q & ris_q) | (fall_raw & msk_q & fal_q);

  // Register writes and flag update; a same-edge event overrides any clear
  always_comb begin
    msk_d  = msk_q;
    ris_d  = ris_q;
    fal_d  = fal_q;
    ctl_d  = ctl_q;
    wr_clr = '0;
    if (wr) begin
      case (reg_off)
        REG_PCMSK: msk_d  = data_i[BITS-1:0];
        REG_PCRIS: ris_d  = data_i[BITS-1:0];
        REG_PCFAL: fal_d  = data_i[BITS-1:0];
        REG_PCFLG: wr_clr = data_i[BITS-1:0];
        REG_PCCTL: ctl_d  = data_i[1:0];
        default:   wr_clr = '0;
      endcase
    end else begin
      wr_clr = '0;
    end
    if (irq_ack_i && ena_i) begin
      ack_clr = '1;
    end else begin
      ack_clr = '0;
    end
    flg_d = (flg_q & ~(wr_clr | ack_clr)) | ev;
  end

  // Read mux; unimplemented bits read as zero
  always_comb begin
    rd_data = 8'h00;
    if (re_i && hit) begin
      case (reg_off)
        REG_PCMSK: rd_data[BITS-1:0] = msk_q;
        REG_PCRIS: rd_data[BITS-1:0] = ris_q;
        REG_PCFAL: rd_data[BITS-1:0] = fal_q;
        REG_PCFLG: rd_data[BITS-1:0] = flg_q;
        REG_PCCTL: rd_data[1:0]      = ctl_q;
        default:   rd_data = 8'h00;
      endcase
    end else begin
      rd_data = 8'h00;
    end
  end

  // Control and flag registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      msk_q <= '0;
      ris_q <= '0;
      fal_q <= '0;
      flg_q <= '0;
      ctl_q <= 2'b00;
    end else begin
      msk_q <= msk_d;
      ris_q <= ris_d;
      fal_q <= fal_d;
      flg_q <= flg_d;
      ctl_q <= ctl_d;
    end
  end

  assign data_o     = rd_data;
  assign selected_o = re_i & hit;
  assign irq_o      = ctl_q[PCCTL_IE] & (|flg_q);

endmodule

// File: tb/tb_pcint_ctrl.sv
// Self-checking bench for pcint_ctrl: directed scenarios with fixed expectations
// plus randomized traffic compared against a pin-history reference model.
`timescale 1ns/1ps
module tb_pcint_ctrl;
  localparam int         BITS = 8;
  localparam logic [5:0] BASE = 6'h0C;
  localparam int         F    = 4;

  logic       clk = 1'b0;
  logic       rst, ena, re, we, sel, irq, irq_ack;
  logic [5:0] adr;
  logic [7:0] din, dout, port;
  int         checks = 0;
  int         failures = 0;

  always #10 clk = ~clk;

  pcint_ctrl #(.BITS(BITS), .ADR_BASE(BASE), .FILT_CYC(F)) dut (
    .clk_i(clk), .rst_i(rst), .ena_i(ena), .adr_i(adr), .data_i(din), .data_o(dout),
    .re_i(re), .we_i(we), .selected_o(sel), .port_i(port), .irq_o(irq), .irq_ack_i(irq_ack)
  );

  // Reference model: accepted level derived from the history of sampled pin values
  logic [7:0] m_msk, m_ris, m_fal, m_flg, m_f;
  logic [1:0] m_ctl;
  logic [7:0] hist_p[$];
  bit         hist_fe[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_msk <= 8'h00; m_ris <= 8'h00; m_fal <= 8'h00; m_flg <= 8'h00; m_f <= 8'h00; m_ctl <= 2'b00;
      hist_p.delete(); hist_fe.delete();
      for (int j = 0; j < F + 2; j++) begin
        hist_p.push_back(8'h00);
        hist_fe.push_back(1'b0);
      end
    end else begin : upd
      logic [7:0] nf, ev, clr;
      int         k;
      bit         acc;
      hist_p.push_back(port);
      hist_fe.push_back(m_ctl[1]);
      k  = hist_p.size() - 1;
      nf = m_f;
      for (int i = 0; i < 8; i++) begin
        if (!m_ctl[1]) begin
          nf[i] = hist_p[k-2][i];
        end else begin
          acc = 1'b1;
          for (int j = k - F + 1; j <= k; j++)
            if (!hist_fe[j] || hist_p[j-2][i] == m_f[i]) acc = 1'b0;
          if (acc) nf[i] = ~m_f[i];
        end
      end
      ev  = (nf & ~m_f & m_msk & m_ris) | (~nf & m_f & m_msk & m_fal);
      clr = 8'h00;
      if (irq_ack && ena) clr = 8'hFF;
      if (we && ena && adr == BASE + 6'd3) clr = clr | din;
      m_flg <= (m_flg & ~clr) | ev;
      m_f   <= nf;
      if (we && ena) begin
        case (adr)
          BASE:         m_msk <= din;
          BASE + 6'd1:  m_ris <= din;
          BASE + 6'd2:  m_fal <= din;
          BASE + 6'd4:  m_ctl <= din[1:0];
          default:      ;
        endcase
      end
    end
  end

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    we = 1'b1; ena = 1'b1; adr = BASE + {3'b000, off}; din = d;
    @(negedge clk);
    we = 1'b0; din = 8'h00;
  endtask

  task automatic rd(input logic [2:0] off, output logic [7:0] d);
    re = 1'b1; adr = BASE + {3'b000, off};
    #1;
    d = dout;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    wr(3'd0, 8'hA5); wr(3'd1, 8'h5A); wr(3'd2, 8'h3C); wr(3'd4, 8'h03);
    rd(3'd0, d);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL pre_reset_msk got=%h exp=a5", d); end
    #1 rst = 1'b1;
    for (int o = 0; o < 5; o++) begin
      rd(3'(o), d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL reset_reg%0d got=%h exp=00", o, d); end
    end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    rd(3'd5, d);
    checks++; if (d !== 8'h00 || sel !== 1'b0) begin failures++; $display("FAIL out_of_window got=%h/%b exp=00/0", d, sel); end
    rd(3'd0, d);
    checks++; if (sel !== 1'b1) begin failures++; $display("FAIL in_window_sel got=%b exp=1", sel); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unfiltered_rise;
    logic [7:0] d;
    logic [7:0] exp_flg[3];
    exp_flg[0] = 8'h00; exp_flg[1] = 8'h00; exp_flg[2] = 8'h01;
    wr(3'd0, 8'h01); wr(3'd1, 8'h01); wr(3'd4, 8'h01);
    port[0] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      rd(3'd3, d);
      checks++; if (d !== exp_flg[c]) begin failures++; $display("FAIL rise_edge_n%0d got=%h exp=%h", c, d, exp_flg[c]); end
    end
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL rise_irq got=%b exp=1", irq); end
    wr(3'd3, 8'h01);
    port[0] = 1'b0;
    repeat (6) @(negedge clk);
    rd(3'd3, d);
    checks++; if (d !== 8'h00 || irq !== 1'b0) begin failures++; $display("FAIL fall_ignored got=%h/%b exp=00/0", d, irq); end
  endtask

  task automatic test_any_change;
    logic [7:0] d;
    wr(3'd0, 8'h08); wr(3'd1, 8'h08); wr(3'd2, 8'h08);
    port[3] = 1'b1;
    repeat (3) @(negedge clk);
    rd(3'd3, d);
    checks++; if (d !== 8'h08) begin failures++; $display("FAIL any_rise got=%h exp=08", d); end
    wr(3'd3, 8'h08); rd(3'd3, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL w1c_clear got=%h exp=00", d); end
    port[3] = 1'b0;
    repeat (3) @(negedge clk);
    rd(3'd3, d);
    checks++; if (d !== 8'h08) begin failures++; $display("FAIL any_fall got=%h exp=08", d); end
    wr(3'd3, 8'hF7); rd(3'd3, d);
    checks++; if (d !== 8'h08) begin failures++; $display("FAIL w0_keeps got=%h exp=08", d); end
    wr(3'd3, 8'h08);
  endtask

  task automatic test_filter;
    logic [7:0] d;
    wr(3'd4, 8'h03); wr(3'd0, 8'h02); wr(3'd1, 8'h02); wr(3'd2, 8'h00);
    repeat (4) @(negedge clk);
    port[1] = 1'b1;
    repeat (3) @(negedge clk);
    port[1] = 1'b0;
    repeat (8) @(negedge clk);
    rd(3'd3, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL short_pulse got=%h exp=00", d); end
    port[1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      rd(3'd3, d);
      if (c == 4) begin
        checks++; if (d !== 8'h00) begin failures++; $display("FAIL filt_early got=%h exp=00", d); end
      end else if (c == 5) begin
        checks++; if (d !== 8'h02 || irq !== 1'b1) begin failures++; $display("FAIL filt_accept got=%h/%b exp=02/1", d, irq); end
      end
    end
    port[1] = 1'b0;
    repeat (8) @(negedge clk);
    wr(3'd3, 8'h02); wr(3'd4, 8'h01);
  endtask

  task automatic test_collision;
    logic [7:0] d;
    wr(3'd0, 8'h04); wr(3'd1, 8'h04); wr(3'd2, 8'h00);
    port[2] = 1'b1;
    repeat (2) @(negedge clk);
    irq_ack = 1'b1; ena = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    rd(3'd3, d);
    checks++; if (d !== 8'h04 || irq !== 1'b1) begin failures++; $display("FAIL ack_collision got=%h/%b exp=04/1", d, irq); end
    irq_ack = 1'b1; ena = 1'b0;
    @(negedge clk);
    irq_ack = 1'b0; ena = 1'b1;
    rd(3'd3, d);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL ack_no_ena got=%h exp=04", d); end
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    rd(3'd3, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL ack_clear got=%h exp=00", d); end
    port[2] = 1'b0;
    repeat (4) @(negedge clk);
    port[2] = 1'b1;
    repeat (2) @(negedge clk);
    wr(3'd3, 8'h04);
    rd(3'd3, d);
    checks++; if (d !== 8'h04 || irq !== 1'b1) begin failures++; $display("FAIL w1c_collision got=%h/%b exp=04/1", d, irq); end
    we = 1'b1; ena = 1'b0; adr = BASE + 6'd3; din = 8'hFF;
    @(negedge clk);
    we = 1'b0; ena = 1'b1;
    rd(3'd3, d);
    checks++; if (d !== 8'h04) begin failures++; $display("FAIL write_no_ena got=%h exp=04", d); end
  endtask

  task automatic test_masking;
    logic [7:0] d;
    wr(3'd0, 8'h00); rd(3'd3, d);
    checks++; if (d !== 8'h04 || irq !== 1'b1) begin failures++; $display("FAIL mask_keeps got=%h/%b exp=04/1", d, irq); end
    wr(3'd4, 8'h00);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL ie_off got=%b exp=0", irq); end
    wr(3'd4, 8'h01);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL ie_on got=%b exp=1", irq); end
    wr(3'd3, 8'h04);
  endtask

  task automatic test_random;
    logic [7:0] d;
    wr(3'd0, 8'($urandom)); wr(3'd1, 8'($urandom)); wr(3'd2, 8'($urandom)); wr(3'd4, 8'h01);
    for (int n = 0; n < 600; n++) begin
      rd(3'd3, d);
      checks++; if (d !== m_flg) begin failures++; $display("FAIL rand_flg n=%0d got=%h exp=%h", n, d, m_flg); end
      checks++; if (irq !== (m_ctl[0] & (|m_flg))) begin failures++; $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq, m_ctl[0] & (|m_flg)); end
      if (n == 400) begin
        rst = 1'b1; #2 rst = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) port = 8'($urandom);
      ena     = ($urandom_range(0, 7) != 0);
      irq_ack = ($urandom_range(0, 19) == 0);
      we      = ($urandom_range(0, 11) == 0);
      adr     = BASE + 6'($urandom_range(0, 4));
      din     = 8'($urandom);
      if (n % 60 == 30) begin
        we = 1'b1; ena = 1'b1; adr = BASE + 6'd4; din = {6'b000000, 1'($urandom), 1'b1};
      end
      @(negedge clk);
    end
    we = 1'b0; irq_ack = 1'b0; ena = 1'b1;
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; re = 1'b0; we = 1'b0; irq_ack = 1'b0;
    adr = 6'h00; din = 8'h00; port = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_unfiltered_rise();
    test_any_change();
    test_filter();
    test_collision();
    test_masking();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
